// File: rtl/signed_shift_add_mult.sv
// signed_shift_add_mult
//
// Sequential signed (two's-complement) multiplier built from a small
// control FSM and an A/B/X/M datapath. The multiplier is loaded into B,
// the multiplicand is latched into M on start, and the product is built
// one multiplier bit at a time. Each bit gets an add step followed by an
// arithmetic right shift. The final (sign) bit uses a subtract step, which
// supplies the two's-complement correction. The 2*WIDTH-bit product ends
// up in {A,B}, with X holding the sign extension of A.
//
// Configuration macro:
//   SIGNED_MULT_SKIP_ZERO_EN - when defined, the FSM skips ADD/SUB for
//   multiplier bits that are 0. Latency then becomes
//   1+WIDTH+popcount(B_loaded) edges, and the product is unchanged.
//   When the macro is undefined, latency is fixed at 1+2*WIDTH edges.
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-high reset
//   clearA_loadB  in IDLE: clear A and X, load B from sw (wins over execute)
//   execute       in IDLE: start a multiplication; hold to stay in DONE
//   sw[WIDTH-1:0] multiplier on load, multiplicand on start
//   A[WIDTH-1:0]  product high half / accumulator
//   B[WIDTH-1:0]  product low half / multiplier shift register
//   X             sign-extension bit of A
//   busy          high in CLR, ADD, SUB and SHIFT
//   done          high in DONE
module signed_shift_add_mult #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clearA_loadB,
  input  logic             execute,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             X,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT     = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PENULT_BIT   = CW'(WIDTH - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_ADD,
    S_SUB,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             x_q, x_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH:0]   sum_ext;

  // State register and all datapath flops.
  // NOTE: sequential state uses non-blocking assignments only. This keeps
  // every flop sampling its pre-edge value regardless of evaluation order.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous. It is sampled only on clk and can
    // abort a multiplication in any state.
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      x_q     <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      x_q     <= x_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic.
  // NOTE: every variable written in an always_comb gets a default first.
  // This prevents an unassigned path from inferring a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (!clearA_loadB && execute) state_d = S_CLR;
      end
      S_CLR: begin
        // cnt restarts at 0, which is never the last bit since WIDTH >= 2.
`ifdef SIGNED_MULT_SKIP_ZERO_EN
        state_d = b_q[0] ? S_ADD : S_SHIFT;
`else
        state_d = S_ADD;
`endif
      end
      S_ADD, S_SUB: state_d = S_SHIFT;
      S_SHIFT: begin
        if (cnt_q == LAST_BIT) begin
          state_d = S_DONE;
        end else begin
          // b_q[1] becomes B[0] after this shift, so it decides the next step.
`ifdef SIGNED_MULT_SKIP_ZERO_EN
          if (!b_q[1])                    state_d = S_SHIFT;
          else if (cnt_q == PENULT_BIT)   state_d = S_SUB;
          else                            state_d = S_ADD;
`else
          state_d = (cnt_q == PENULT_BIT) ? S_SUB : S_ADD;
`endif
        end
      end
      S_DONE: begin
        if (!execute) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath. The add/sub runs in WIDTH+1 bits so that the carry-out lands
  // in X as the true sign of the partial product.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    x_d     = x_q;
    cnt_d   = cnt_q;
    sum_ext = (state_q == S_SUB) ? ({a_q[WIDTH-1], a_q} - {m_q[WIDTH-1], m_q})
                                 : ({a_q[WIDTH-1], a_q} + {m_q[WIDTH-1], m_q});
    unique case (state_q)
      S_IDLE: begin
        if (clearA_loadB) begin
          a_d = '0;
          x_d = 1'b0;
          b_d = sw;
        end
      end
      S_CLR: begin
        m_d   = sw;
        a_d   = '0;
        x_d   = 1'b0;
        cnt_d = '0;
      end
      S_ADD, S_SUB: begin
        if (b_q[0]) {x_d, a_d} = sum_ext;
      end
      S_SHIFT: begin
        // Arithmetic shift of {X,A,B}: X replicates into A's MSB.
        a_d   = {x_q, a_q[WIDTH-1:1]};
        b_d   = {a_q[0], b_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
      end
      default: ;
    endcase
  end

  // Status outputs are decoded from the next state and then registered.
  // This makes busy/done track the state without any input-to-output path.
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    unique case (state_d)
      S_CLR, S_ADD, S_SUB, S_SHIFT: busy_d = 1'b1;
      S_DONE:                       done_d = 1'b1;
      default: ;
    endcase
  end

  assign A    = a_q;
  assign B    = b_q;
  assign X    = x_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_signed_shift_add_mult.sv
// Self-checking bench for signed_shift_add_mult (WIDTH=8).
// A cycle-level behavioural model runs next to the DUT. It tracks only the
// idle/busy/done phase, the loaded multiplier and the multiplicand. At
// completion it sets {A,B} to the signed product computed with plain
// arithmetic. A compare process checks the DUT against the model on every
// negative edge. Directed runs add literal expectations on top of that.
module tb_signed_shift_add_mult;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         clear_load;
  logic         execute;
  logic [W-1:0] sw;
  logic [W-1:0] dut_a, dut_b;
  logic         dut_x, dut_busy, dut_done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  signed_shift_add_mult #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .clearA_loadB (clear_load),
    .execute      (execute),
    .sw           (sw),
    .A            (dut_a),
    .B            (dut_b),
    .X            (dut_x),
    .busy         (dut_busy),
    .done         (dut_done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_BUSY, M_DONE} mstate_t;

  mstate_t      ms = M_IDLE;
  logic [W-1:0] ea = '0, eb = '0, mult = '0, mcand = '0;
  logic         ex = 1'b0;
  int           elapsed = 0, lat = 0;
  bit           chk_en = 1'b0;

  function automatic int latency_for(input logic [W-1:0] b);
`ifdef SIGNED_MULT_SKIP_ZERO_EN
    return 1 + W + $countones(b);
`else
    return 1 + 2 * W + 0 * $countones(b);
`endif
  endfunction

  function automatic logic [2*W-1:0] product(input logic [W-1:0] b, input logic [W-1:0] m);
    logic signed [2*W-1:0] p;
    p = $signed(b) * $signed(m);
    return p;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      ms <= M_IDLE;
      ea <= '0;
      eb <= '0;
      ex <= 1'b0;
    end else begin
      case (ms)
        M_IDLE: begin
          if (clear_load) begin
            ea <= '0;
            ex <= 1'b0;
            eb <= sw;
          end else if (execute) begin
            ms      <= M_BUSY;
            mult    <= eb;
            lat     <= latency_for(eb);
            elapsed <= 0;
          end
        end
        M_BUSY: begin
          elapsed <= elapsed + 1;
          if (elapsed == 0) mcand <= sw;
          if (elapsed + 1 == lat) begin
            {ea, eb} <= product(mult, mcand);
            ex       <= product(mult, mcand) >> (2 * W - 1);
            ms       <= M_DONE;
          end
        end
        M_DONE: begin
          if (!execute) ms <= M_IDLE;
        end
        default: ms <= M_IDLE;
      endcase
    end
  end

  // Compare process: status every cycle, data whenever it is architecturally defined.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", dut_busy, ms == M_BUSY);
      check("done", dut_done, ms == M_DONE);
      if (ms != M_BUSY) begin
        check("A", dut_a, ea);
        check("B", dut_b, eb);
        check("X", dut_x, ex);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic load_b(input logic [W-1:0] b);
    @(negedge clk);
    clear_load = 1'b1;
    sw         = b;
    @(negedge clk);
    clear_load = 1'b0;
  endtask

  // Press execute with multiplicand s. Returns the edge count (edge 0 =
  // the press) at which done was first seen, or -1 on timeout.
  // With glitch set, clearA_loadB is pulsed mid-run with a junk sw.
  task automatic run(input logic [W-1:0] s, input bit glitch, output int edges);
    @(negedge clk);
    sw      = s;
    execute = 1'b1;
    @(posedge clk);
    edges = -1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk);
      #1;
      if (glitch && k == 3) begin
        clear_load = 1'b1;
        sw         = 8'hAA;
      end
      if (glitch && k == 4) clear_load = 1'b0;
      if (dut_done) begin
        edges = k;
        break;
      end
    end
    if (edges < 0) check("done_timeout", 0, 1);
  endtask

  task automatic release_exec();
    @(negedge clk);
    execute = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e;
    reset      = 1'b1;
    clear_load = 1'b0;
    execute    = 1'b0;
    sw         = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("rst_A", dut_a, 0);
    check("rst_B", dut_b, 0);
    check("rst_busy", dut_busy, 0);
    check("rst_done", dut_done, 0);
    @(negedge clk);
    reset = 1'b0;

    // 7 * 3 = 21
    load_b(8'h07);
    run(8'h03, 1'b0, e);
`ifdef SIGNED_MULT_SKIP_ZERO_EN
    check("lat_7x3", e, 12);
`else
    check("lat_7x3", e, 17);
`endif
    check("7x3_A", dut_a, 8'h00);
    check("7x3_B", dut_b, 8'h15);
    check("7x3_X", dut_x, 1'b0);
    release_exec();

    // 7 * -3 = -21
    load_b(8'h07);
    run(8'hFD, 1'b0, e);
    check("7xm3_A", dut_a, 8'hFF);
    check("7xm3_B", dut_b, 8'hEB);
    check("7xm3_X", dut_x, 1'b1);
    release_exec();

    // -128 * -128 = +16384, exercises the final subtract
    load_b(8'h80);
    run(8'h80, 1'b0, e);
    check("m128sq_A", dut_a, 8'h40);
    check("m128sq_B", dut_b, 8'h00);
    check("m128sq_X", dut_x, 1'b0);
    release_exec();

    // Hold execute in DONE for 40 cycles, then chain without reload.
    load_b(8'h07);
    run(8'hFD, 1'b0, e);
    repeat (40) @(negedge clk);
    check("hold_done", dut_done, 1'b1);
    check("hold_A", dut_a, 8'hFF);
    check("hold_B", dut_b, 8'hEB);
    release_exec();
    run(8'h02, 1'b0, e);
    check("chain_A", dut_a, 8'hFF);
    check("chain_B", dut_b, 8'hD6);
    release_exec();

    // clearA_loadB during busy is ignored.
    load_b(8'h07);
    run(8'h03, 1'b1, e);
    check("glitch_B", dut_b, 8'h15);
    check("glitch_A", dut_a, 8'h00);
    release_exec();

    // Reset at edge 6 of a run.
    load_b(8'h55);
    @(negedge clk);
    sw      = 8'h37;
    execute = 1'b1;
    @(posedge clk);                 // edge 0
    repeat (5) @(posedge clk);      // edges 1..5
    @(negedge clk);
    reset   = 1'b1;
    execute = 1'b0;
    @(posedge clk);                 // edge 6
    #1;
    check("midrst_A", dut_a, 0);
    check("midrst_B", dut_b, 0);
    check("midrst_X", dut_x, 0);
    check("midrst_busy", dut_busy, 0);
    check("midrst_done", dut_done, 0);
    @(negedge clk);
    reset = 1'b0;
    load_b(8'h07);
    run(8'h03, 1'b0, e);
    check("postrst_B", dut_b, 8'h15);
    release_exec();

`ifdef SIGNED_MULT_SKIP_ZERO_EN
    load_b(8'h01);
    run(8'h05, 1'b0, e);
    check("skip_lat_1", e, 10);
    check("skip_prod_1", {dut_a, dut_b}, 16'h0005);
    release_exec();
    load_b(8'hFF);
    run(8'h05, 1'b0, e);
    check("skip_lat_ff", e, 17);
    check("skip_prod_ff", {dut_a, dut_b}, 16'hFFFB);
    release_exec();
`endif

    // Randomised runs; the compare process checks every cycle.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) != 0) load_b(W'($urandom));
      if ($urandom_range(0, 7) == 0) begin
        @(negedge clk);
        sw      = W'($urandom);
        execute = 1'b1;
        repeat ($urandom_range(1, 15)) @(posedge clk);
        @(negedge clk);
        reset   = 1'b1;
        execute = 1'b0;
        @(negedge clk);
        reset = 1'b0;
      end else begin
        run(W'($urandom), 1'b0, e);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        release_exec();
      end
    end

    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/signed_shift_add_mult.md
# signed_shift_add_mult

Parametrised sequential signed multiplier (control FSM plus A/B/X/M datapath) for the switch-driven multiplier labs. It generalises the fixed 8-bit add/shift/sub controller to WIDTH bits. It latches the multiplicand, iterates one multiplier bit per add/shift pair with a final-bit subtract (two's-complement correction), and holds the 2·WIDTH-bit product in {A,B}. It sits between debounced switch/button inputs and the hex-display drivers.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32.
- clk  input  1  system clock.
- reset  input  1  reset, synchronous, active-high; clock clk.
- clearA_loadB  input  1  level; in IDLE, clears A and X and loads B from sw.
- execute  input  1  level; in IDLE, starts one multiplication.
- sw  input  WIDTH  operand source: multiplier on load, multiplicand on start.
- A  output  WIDTH  product high half / accumulator.
- B  output  WIDTH  product low half / multiplier shift register.
- X  output  1  sign-extension bit of A.
- busy  output  1  high in CLR, ADD, SUB and SHIFT.
- done  output  1  high in DONE.

## Operation
- States: IDLE, CLR, ADD, SUB, SHIFT, DONE.
- Internal registers: M[WIDTH-1:0] (multiplicand) and cnt (width $clog2(WIDTH)+1).
- Reset: A=0, B=0, X=0, M=0, cnt=0, state=IDLE, busy=0, done=0. Applies in any state, including mid-operation.
- IDLE input priority is clearA_loadB > execute.
  - clearA_loadB=1: A<=0, X<=0, B<=sw; stay in IDLE.
  - Otherwise execute=1: go to CLR.
- clearA_loadB is ignored outside IDLE.
- CLR: M<=sw, A<=0, X<=0, cnt<=0.
- Per-bit step: ADD when cnt<WIDTH-1, SUB when cnt==WIDTH-1.
  - If B[0]=1: {X,A} <= sext(A) ± sext(M), computed in WIDTH+1 bits; X is bit WIDTH of the result.
  - If B[0]=0: {X,A} is held.
  - Next state is SHIFT.
- SHIFT: arithmetic right shift of {X,A,B}.
  - X is unchanged, A<={X,A[W-1:1]}, B<={A[0],B[W-1:1]}, cnt<=cnt+1.
  - If cnt==WIDTH-1 before the increment, go to DONE; otherwise go to the next per-bit step.
- DONE: {A,B} holds the signed product of the loaded B and M.
  - Stays in DONE while execute=1; goes to IDLE when execute=0. One multiplication per press.
- Chaining: B keeps the product low half, so a new execute without a reload multiplies that value by the new sw.
- Overflow cannot occur: the WIDTH+1-bit sum holds every partial product, and (-2^(W-1))² fits in 2·WIDTH signed bits.

## Timing
- execute is sampled at edge 0; CLR executes at edge 1.
- Baseline: exactly WIDTH ADD/SUB cycles plus WIDTH SHIFT cycles. DONE is entered at edge 1+2·WIDTH (edge 17 for WIDTH=8).
- done asserts the cycle DONE is entered and deasserts one cycle after execute is seen low.
- Outputs are registers with no combinational paths from inputs.
- Reset asserted during busy: all outputs are at their reset values the cycle after the reset edge, and the partial product is discarded.

## Configuration
- SIGNED_MULT_SKIP_ZERO_EN defined:
  - From CLR or SHIFT, if the B[0] value that the next step would use is 0, go directly to SHIFT and skip ADD/SUB.
  - Latency becomes 1+WIDTH+popcount(B_loaded) edges to DONE.
  - Product values are identical to the baseline.
- Undefined: fixed latency of 1+2·WIDTH edges. ADD/SUB is always visited, and holds when B[0]=0.

## Test plan
- WIDTH=8: load B=0x07, execute with sw=0x03 -> A=0x00, B=0x15, X=0, done at edge 17 (baseline).
- Load B=0x07, execute with sw=0xFD -> A=0xFF, B=0xEB, X=1 (-21).
- Load B=0x80, execute with sw=0x80 -> A=0x40, B=0x00, X=0 (+16384, tests the SUB correction).
- Hold execute for 40 cycles after done -> state stays DONE and A/B are unchanged.
  - Release, then press again with sw=0x02 without reloading -> B=0xD6 (0xEB×2 low byte).
- Assert reset at edge 6 of a run -> next cycle A=B=X=0, busy=0, done=0, state IDLE.
  - clearA_loadB pulsed during busy has no effect.
- With SIGNED_MULT_SKIP_ZERO_EN: B=0x01, sw=0x05 -> product 0x0005, done at edge 10.
  - B=0xFF, sw=0x05 -> product 0xFFFB, done at edge 17.
